// File: rtl/timer_mmio.sv
// -----------------------------------------------------------------------------
// timer_mmio
//   Memory-mapped countdown timer attached to the Memory-stage data bus.
//   It snoops the store bus for writes to its four registers and returns read
//   data combinationally for the load path. It raises a registered interrupt
//   request on expiry. Instantiate twice (different BASE_ADDR) for Timer0/1.
//
//   Register map (offset = addr[3:2]):
//     0x0 CTRL     [0] EN, [2:1] MODE (01 auto-reload, anything else one-shot),
//                  [3] IM (interrupt mask / enable)
//     0x4 PRESET   reload value
//     0x8 COUNT    current count, read-only
//     0xC PRESCALE tick divider (only with TIMER_PRESCALE_EN, else reads 0)
//
//   Build option:
//     TIMER_PRESCALE_EN  when defined, adds a 16-bit prescaler. The count
//                        decrements once every PRESCALE+1 cycles.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-low; clears all state
//     addr   byte address from the Memory stage
//     we     write strobe (already flushed on exceptions upstream)
//     be     byte enables, be[i] covers wd[8i+7:8i]
//     wd     write data (byte-replicated upstream)
//     rd     read data, combinational, 0 when the address misses
//     irq    registered interrupt request toward CP0
// -----------------------------------------------------------------------------
module timer_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_next;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pend, pend_next;

    logic        hit;
    logic [1:0]  offset;
    logic        wr_ctrl, wr_preset;
    logic        ctrl_en, auto_mode, irq_mask;
    logic        tick;
    logic        expire;
    logic        pend_clr;
    logic        unused_addr_bits;

    // Register decode: the block occupies one 16-byte aligned window.
    assign hit              = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset           = addr[3:2];
    assign wr_ctrl          = hit & we & (offset == 2'd0);
    assign wr_preset        = hit & we & (offset == 2'd1);
    assign unused_addr_bits = ^addr[1:0];

    assign ctrl_en   = ctrl[0];
    assign auto_mode = (ctrl[2:1] == 2'b01);
    assign irq_mask  = ctrl[3];

    // Expiry happens on the tick that takes COUNT from 1 (or an already-zero
    // COUNT) down to 0 while the timer is still enabled.
    assign expire = (state == CNT) & ctrl_en & tick & (count <= 32'd1);

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale;
    logic [15:0] div;
    logic        wr_prescale;

    assign wr_prescale = hit & we & (offset == 2'd3);
    assign tick        = (div == prescale);

    // Divider only runs while counting so every period starts from a clean
    // phase; it wraps to zero on the cycle it produces a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= 16'd0;
        end else if (state == CNT) begin
            div <= tick ? 16'd0 : div + 16'd1;
        end else begin
            div <= 16'd0;
        end
    end

    // Prescale register, low two bytes writable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= 16'd0;
        end else if (wr_prescale) begin
            if (be[0]) prescale[7:0]  <= wd[7:0];
            if (be[1]) prescale[15:8] <= wd[15:8];
        end
    end
`else
    assign tick = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and pending-flag logic. In auto-reload the pending flag is
    // a one-cycle marker of INT; in one-shot it is sticky until software
    // touches CTRL or PRESET. A same-edge set always wins over the clear.
    always_comb begin
        state_next = state;
        pend_clr   = 1'b0;
        pend_next  = pend;
        case (state)
            IDLE: if (ctrl_en) state_next = LOAD;
            LOAD: state_next = CNT;
            CNT: begin
                if (!ctrl_en)    state_next = IDLE;
                else if (expire) state_next = INT;
            end
            INT: state_next = auto_mode ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
        pend_clr = auto_mode ? (state == INT) : (wr_ctrl | wr_preset);
        if (expire)        pend_next = 1'b1;
        else if (pend_clr) pend_next = 1'b0;
    end

    // CTRL: a bus write of byte 0 beats the one-shot self-disable in INT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= 4'd0;
        end else if (wr_ctrl && be[0]) begin
            ctrl <= wd[3:0];
        end else if (state == INT && !auto_mode) begin
            ctrl[0] <= 1'b0;
        end
    end

    // PRESET: per-byte update, only sampled into COUNT in LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) preset[8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    // COUNT: loaded in LOAD, decremented on ticks while enabled in CNT,
    // saturating at zero; held everywhere else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 32'd0;
        end else if (state == LOAD) begin
            count <= preset;
        end else if (state == CNT && ctrl_en && tick) begin
            count <= (count <= 32'd1) ? 32'd0 : count - 32'd1;
        end
    end

    // Pending flag and masked, registered interrupt request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
            irq  <= 1'b0;
        end else begin
            pend <= pend_next;
            irq  <= pend_next & irq_mask;
        end
    end

    // Combinational read mux for the load path.
    always_comb begin
        rd = 32'd0;
        if (hit) begin
            case (offset)
                2'd0: rd = {28'd0, ctrl};
                2'd1: rd = preset;
                2'd2: rd = count;
`ifdef TIMER_PRESCALE_EN
                2'd3: rd = {16'd0, prescale};
`else
                2'd3: rd = 32'd0;
`endif
                default: rd = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_mmio.sv
// -----------------------------------------------------------------------------
// tb_timer_mmio
//   Self-checking bench for timer_mmio. Stimulus pushes expected read data
//   and irq into a scoreboard queue; a monitor on the falling edge pops and
//   compares. Expected values come from closed-form timing rules (count
//   sequence, expiry latency, reload period) and a plain register-map model.
// -----------------------------------------------------------------------------
module tb_timer_mmio;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;
    logic        irq;

    always #5 clk = ~clk;

    timer_mmio #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .be    (be),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   edge_count = 0;
    bit   mon_valid = 1'b0;

    // Register-map model for bus tests.
    logic [3:0]  m_ctrl = 4'd0;
    logic [31:0] m_preset = 32'd0;
    logic [31:0] m_count = 32'd0;
    logic [15:0] m_prescale = 16'd0;

    // Monitor: compares the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_empty: rd=%h irq=%b with nothing expected", rd, irq);
            end else begin
                mon_e = sb.pop_front();
                if (rd !== mon_e.rd || irq !== mon_e.irq) begin
                    errors++;
                    $display("[TB] FAIL %s @%0t: got rd=%h irq=%b, expected rd=%h irq=%b",
                             mon_e.name, $time, rd, irq, mon_e.rd, mon_e.irq);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Edges needed from EN-write to INT: max(P,1)*(S+1)+2.
    function automatic int kexp_f(input int p, input int s);
        return ((p < 1) ? 1 : p) * (s + 1) + 2;
    endfunction

    // COUNT seen after edge N+k where N is the EN write edge.
    function automatic logic [31:0] model_count(input int k, input int p, input int s,
                                                input bit am, input logic [31:0] prev);
        int ke;
        int j;
        ke = kexp_f(p, s);
        if (k < 2) return prev;
        j = k - 2;
        if (am) j = j % ke;
        if (j >= ke - 2) return 32'd0;
        return 32'(p - j / (s + 1));
    endfunction

    // irq seen after edge N+k.
    function automatic logic model_irq(input int k, input int p, input int s,
                                       input bit am, input bit im);
        int ke;
        ke = kexp_f(p, s);
        if (!im || k < 2) return 1'b0;
        if (am) return ((k - 2) % ke) == (ke - 2);
        return k >= ke;
    endfunction

    function automatic logic [31:0] model_view(input logic [1:0] off);
        case (off)
            2'd0: return {28'd0, m_ctrl};
            2'd1: return m_preset;
            2'd2: return m_count;
            default: begin
`ifdef TIMER_PRESCALE_EN
                return {16'd0, m_prescale};
`else
                return 32'd0;
`endif
            end
        endcase
    endfunction

    // One bus write; returns one step after the write edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        addr = a; be = b; wd = d; we = 1'b1;
        @(posedge clk);
        edge_count++;
        #1;
        we = 1'b0; be = 4'd0;
    endtask

    // One read; the expectation is queued for the monitor.
    task automatic checkOutput(input string name, input logic [31:0] a,
                               input logic [31:0] er, input logic ei);
        exp_t e;
        addr = a; we = 1'b0;
        e.name = name; e.rd = er; e.irq = ei;
        sb.push_back(e);
        mon_valid = 1'b1;
        @(posedge clk);
        edge_count++;
        #1;
        mon_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            edge_count++;
            #1;
        end
    endtask

    // Read COUNT each cycle from the current step up to k = kend.
    task automatic check_count_run(input string tag, input int n0, input int kend, input int p,
                                   input int s, input bit am, input bit im, input logic [31:0] prev);
        for (int k = edge_count - n0; k <= kend; k++) begin
            checkOutput(tag, BASE + 32'd8, model_count(k, p, s, am, prev), model_irq(k, p, s, am, im));
        end
    endtask

    initial begin
        int          n0;
        int          kd;
        int          p;
        int          mi;
        logic [1:0]  mode;
        logic        im;
        logic [3:0]  cv;
        logic [31:0] frozen;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [1:0]  off;
        bit          is_hit;

        @(posedge clk);
        #1;

        // Reset state, then idle after release.
        for (int o = 0; o < 4; o++) checkOutput("reset_rd", BASE + 32'(4 * o), 32'd0, 1'b0);
        reset = 1'b1;
        idle(10);
        for (int o = 0; o < 4; o++) checkOutput("idle_rd", BASE + 32'(4 * o), 32'd0, 1'b0);

        // One-shot, PRESET=5, IM set.
        applyStimulus(BASE + 32'd4, 4'hF, 32'd5);
        applyStimulus(BASE, 4'h1, 32'h9);
        n0 = edge_count;
        check_count_run("oneshot_cnt", n0, kexp_f(5, 0) + 1, 5, 0, 1'b0, 1'b1, 32'd0);
        checkOutput("oneshot_ctrl", BASE, 32'h8, 1'b1);
        for (int i = 0; i < 3; i++) checkOutput("irq_sticky", BASE + 32'd8, 32'd0, 1'b1);
        applyStimulus(BASE, 4'h1, 32'h8);
        checkOutput("irq_clear", BASE, 32'h8, 1'b0);

        // Randomized one-shot runs, including MODE=1x and IM=0.
        repeat (4) begin
            p    = $urandom_range(0, 12);
            mi   = $urandom_range(0, 2);
            mode = (mi == 0) ? 2'b00 : ((mi == 1) ? 2'b10 : 2'b11);
            im   = 1'($urandom_range(0, 1));
            cv   = {im, mode, 1'b1};
            applyStimulus(BASE + 32'd4, 4'hF, 32'(p));
            applyStimulus(BASE, 4'h1, {28'd0, cv});
            n0 = edge_count;
            check_count_run("rand_oneshot", n0, kexp_f(p, 0) + 1, p, 0, 1'b0, im, 32'd0);
            checkOutput("rand_ctrl", BASE, {28'd0, cv & 4'hE}, im);
        end

        // Auto-reload, PRESET=3: 1-cycle irq every 5 cycles, then disable.
        applyStimulus(BASE + 32'd4, 4'hF, 32'd3);
        applyStimulus(BASE, 4'h1, 32'hB);
        n0 = edge_count;
        check_count_run("auto", n0, 22, 3, 0, 1'b1, 1'b1, 32'd0);
        applyStimulus(BASE, 4'h1, 32'h8);
        kd = edge_count - n0;
        frozen = model_count(kd, 3, 0, 1'b1, 32'd0);
        checkOutput("auto_stop", BASE + 32'd8, frozen, model_irq(kd, 3, 0, 1'b1, 1'b1));
        checkOutput("auto_frozen", BASE + 32'd8, frozen, 1'b0);

        // PRESET rewrite during CNT, freeze, COUNT write ignored, reload.
        applyStimulus(BASE + 32'd4, 4'hF, 32'd20);
        applyStimulus(BASE, 4'h1, 32'h1);
        n0 = edge_count;
        check_count_run("frz_run", n0, 6, 20, 0, 1'b0, 1'b0, frozen);
        applyStimulus(BASE + 32'd4, 4'hF, 32'd100);
        checkOutput("preset_in_cnt", BASE + 32'd8, model_count(edge_count - n0, 20, 0, 1'b0, frozen), 1'b0);
        applyStimulus(BASE, 4'h1, 32'h0);
        kd = edge_count - n0;
        frozen = model_count(kd, 20, 0, 1'b0, frozen);
        for (int i = 0; i < 3; i++) checkOutput("frozen", BASE + 32'd8, frozen, 1'b0);
        checkOutput("preset_new", BASE + 32'd4, 32'd100, 1'b0);
        applyStimulus(BASE + 32'd8, 4'hF, 32'hFFFF_FFFF);
        checkOutput("count_ro", BASE + 32'd8, frozen, 1'b0);
        applyStimulus(BASE, 4'h1, 32'h1);
        n0 = edge_count;
        check_count_run("reload", n0, 3, 100, 0, 1'b0, 1'b0, frozen);
        applyStimulus(BASE, 4'h1, 32'h0);
        kd = edge_count - n0;
        m_count = model_count(kd, 100, 0, 1'b0, frozen);
        idle(2);
        checkOutput("reload_frozen", BASE + 32'd8, m_count, 1'b0);

        // Byte enables and address decode.
        m_ctrl = 4'd0;
        applyStimulus(BASE + 32'd4, 4'hF, 32'd0);
        applyStimulus(BASE + 32'd4, 4'b0010, 32'hAABB_CCDD);
        m_preset = 32'h0000_CC00;
        checkOutput("be_preset", BASE + 32'd4, m_preset, 1'b0);
        applyStimulus(BASE + 32'h14, 4'hF, 32'h1234_5678);
        checkOutput("miss_rd", BASE + 32'h14, 32'd0, 1'b0);
        checkOutput("miss_keep", BASE + 32'd4, m_preset, 1'b0);
        repeat (24) begin
            off    = 2'($urandom_range(0, 3));
            b      = 4'($urandom_range(0, 15));
            d      = $urandom;
            d[0]   = 1'b0;
            is_hit = ($urandom_range(0, 3) != 0);
            if (is_hit) begin
                a = BASE + 32'(off) * 32'd4 + 32'($urandom_range(0, 3));
            end else begin
                a = $urandom;
                if (a[31:4] == BASE[31:4]) a[31] = ~a[31];
                off = a[3:2];
            end
            applyStimulus(a, b, d);
            if (is_hit) begin
                case (off)
                    2'd0: if (b[0]) m_ctrl = d[3:0];
                    2'd1: for (int i = 0; i < 4; i++) if (b[i]) m_preset[8*i +: 8] = d[8*i +: 8];
                    2'd3: begin
                        if (b[0]) m_prescale[7:0]  = d[7:0];
                        if (b[1]) m_prescale[15:8] = d[15:8];
                    end
                    default: ;
                endcase
            end
            checkOutput("bus_rd", a, is_hit ? model_view(off) : 32'd0, 1'b0);
            checkOutput("bus_reg", BASE + 32'(off) * 32'd4, model_view(off), 1'b0);
        end
        applyStimulus(BASE, 4'hF, 32'd0);
        applyStimulus(BASE + 32'hC, 4'hF, 32'd0);

        // Reset mid-count: everything clears before the next edge.
        applyStimulus(BASE + 32'd4, 4'hF, 32'd40);
        applyStimulus(BASE, 4'h1, 32'h9);
        n0 = edge_count;
        check_count_run("pre_reset", n0, 6, 40, 0, 1'b0, 1'b1, m_count);
        #1 reset = 1'b0;
        for (int o = 0; o < 4; o++) checkOutput("mid_reset", BASE + 32'(4 * o), 32'd0, 1'b0);
        reset = 1'b1;
        idle(5);
        checkOutput("post_reset", BASE + 32'd8, 32'd0, 1'b0);

        // Reset while irq is high drops it asynchronously.
        applyStimulus(BASE + 32'd4, 4'hF, 32'd2);
        applyStimulus(BASE, 4'h1, 32'h9);
        n0 = edge_count;
        check_count_run("irq_before_rst", n0, kexp_f(2, 0) + 1, 2, 0, 1'b0, 1'b1, 32'd0);
        #1 reset = 1'b0;
        checkOutput("irq_async_rst", BASE, 32'd0, 1'b0);
        checkOutput("preset_rst", BASE + 32'd4, 32'd0, 1'b0);
        reset = 1'b1;
        idle(2);

`ifdef TIMER_PRESCALE_EN
        // Prescaled one-shot: PRESCALE=1, PRESET=4 -> irq at N+10.
        applyStimulus(BASE + 32'hC, 4'hF, 32'hFFFF_0001);
        checkOutput("prescale_rd", BASE + 32'hC, 32'd1, 1'b0);
        applyStimulus(BASE + 32'd4, 4'hF, 32'd4);
        applyStimulus(BASE, 4'h1, 32'h9);
        n0 = edge_count;
        check_count_run("prescale_run", n0, kexp_f(4, 1) + 1, 4, 1, 1'b0, 1'b1, 32'd0);
`endif

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
